// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO between the CPU store port and the serial pin.
// First start-bit edge one cycle after acceptance into an empty idle FIFO; data_in_ready = !full.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         data_in,
    input  logic                               data_in_valid,
    output logic                               data_in_ready,
    output logic                               serial_out,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SYM_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           r_state;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [SYM_W-1:0] r_sym_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_serial;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;
    logic w_sym_last;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_FULL);
    assign w_sym_last = (r_sym_cnt == SYM_LAST);
    assign w_push     = data_in_valid && !w_full;
    // Pops happen from IDLE, or on the final stop cycle so frames run back-to-back.
    assign w_pop      = !w_empty && ((r_state == IDLE) || (r_state == STOP && w_sym_last));

    assign data_in_ready = !w_full;
    assign serial_out    = r_serial;
    assign busy          = (r_state != IDLE) || !w_empty;
    assign fifo_count    = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // serial_out is loaded with the level of the bit being entered, so it is purely registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_serial  <= 1'b1;
            r_sym_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_serial <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_sym_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_serial  <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_sym_last) begin
                        r_sym_cnt <= '0;
                        r_serial  <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_sym_last) begin
                        r_sym_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_serial <= 1'b1;
                            r_state  <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_serial  <= r_shift[1];
                        end
                    end else begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_sym_last) begin
                        r_sym_cnt <= '0;
                        if (w_pop) begin
                            r_shift   <= r_mem[r_rd_ptr];
                            r_bit_cnt <= '0;
                            r_serial  <= 1'b0;
                            r_state   <= START;
                        end else begin
                            r_serial <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end else begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                    end
                end
                default: begin
                    r_serial <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a line monitor decodes every frame sample-by-sample against a queue of accepted bytes.
module tb_uart_transmitter;

    localparam int CLK_F = 1_000_000;
    localparam int BAUD  = 100_000;
    localparam int DEPTH = 8;
    localparam int SET   = CLK_F / BAUD;
    localparam int FRAME = 10 * SET;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    bit         in_frame = 1'b0;
    int         n_frames = 0;

    uart_transmitter #(.CLOCK_FREQ(CLK_F), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .serial_out(serial_out), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected line level at sample k of a frame carrying byte b.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        int slot = k / SET;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    // Line monitor: acts as the receiver, checking each cycle of every frame.
    initial begin
        logic [7:0] cur = 8'h00;
        int k = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                exp_q.delete();
            end else begin
                if (!in_frame && serial_out === 1'b0) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_start: line low at cycle %0d with no byte pending", cyc);
                        cur = 8'h00;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    in_frame = 1'b1;
                    k = 0;
                    start_q.push_back(cyc);
                    n_frames++;
                end
                if (in_frame) begin
                    n_vec++;
                    if (serial_out !== exp_line(cur, k)) begin
                        n_err++;
                        $display("FAIL line_bit: byte %02h sample %0d got %b want %b", cur, k, serial_out, exp_line(cur, k));
                    end
                    k++;
                    if (k == FRAME) in_frame = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present b and hold valid until accepted; valid is left high for back-to-back pushes.
    task automatic push(input logic [7:0] b, output int acc_cyc);
        bit ok = 1'b0;
        data_in = b;
        data_in_valid = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (data_in_ready) begin ok = 1'b1; break; end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL push_timeout: byte %02h never accepted, ready=%b want 1", b, data_in_ready);
            data_in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && !in_frame) break;
        end
        n_vec++;
        if (busy || in_frame || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: busy=%b in_frame=%b pending=%0d want 0/0/0", busy, in_frame, exp_q.size());
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        n_vec++; if (serial_out !== 1'b1) begin n_err++; $display("FAIL rst_serial: got %b want 1", serial_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (fifo_count !== 0) begin n_err++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        n_vec++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", data_in_ready); end
        rst = 1'b0;
        step();
        @(negedge clk);
        n_vec++; if (serial_out !== 1'b1) begin n_err++; $display("FAIL idle_serial: got %b want 1", serial_out); end
        step();
    endtask

    task automatic test_single();
        int e0;
        int bad = 0;
        start_q.delete();
        push(8'hA5, e0);
        data_in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (serial_out !== 1'b1) begin n_err++; $display("FAIL single_accept_serial: got %b want 1", serial_out); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_accept_busy: got %b want 1", busy); end
        n_vec++; if (fifo_count !== 1) begin n_err++; $display("FAIL single_accept_count: got %0d want 1", fifo_count); end
        @(negedge clk);
        n_vec++; if (serial_out !== 1'b0) begin n_err++; $display("FAIL single_latency: serial got %b want 0", serial_out); end
        for (int i = 1; i < FRAME; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL single_busy_frame: %0d low cycles want 0", bad); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || serial_out !== 1'b1) begin
            n_err++; $display("FAIL single_end: busy=%b serial=%b want 0/1", busy, serial_out);
        end
        n_vec++; if (start_q.size() != 1 || start_q[0] != e0 + 1) begin
            n_err++; $display("FAIL single_start_cycle: frames=%0d start=%0d want 1/%0d", start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, e0 + 1);
        end
        wait_drain(200);
    endtask

    task automatic test_back_to_back();
        start_q.delete();
        data_in = 8'h00;
        data_in_valid = 1'b1;
        @(negedge clk);
        n_vec++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", data_in_ready); end
        @(posedge clk); #1;
        exp_q.push_back(8'h00);
        data_in = 8'hFF;
        @(negedge clk);
        n_vec++; if (fifo_count !== 1) begin n_err++; $display("FAIL b2b_count_a: got %0d want 1", fifo_count); end
        @(posedge clk); #1;
        exp_q.push_back(8'hFF);
        data_in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (fifo_count !== 1) begin n_err++; $display("FAIL b2b_count_b: got %0d want 1", fifo_count); end
        for (int i = 0; i < 400 && cyc < start_q[0] + FRAME - 1; i++) @(negedge clk);
        n_vec++; if (fifo_count !== 1) begin n_err++; $display("FAIL b2b_count_c: got %0d want 1", fifo_count); end
        @(negedge clk);
        n_vec++; if (fifo_count !== 0) begin n_err++; $display("FAIL b2b_count_d: got %0d want 0", fifo_count); end
        wait_drain(400);
        n_vec++; if (start_q.size() != 2 || start_q[1] - start_q[0] != FRAME) begin
            n_err++; $display("FAIL b2b_gap: frames=%0d spacing=%0d want 2/%0d", start_q.size(), (start_q.size() == 2) ? start_q[1] - start_q[0] : -1, FRAME);
        end
    endtask

    task automatic test_fill();
        int acc;
        start_q.delete();
        for (int i = 0; i < 9; i++) push(8'($urandom), acc);
        data_in = 8'($urandom);
        @(negedge clk);
        n_vec++; if (data_in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b want 0", data_in_ready); end
        n_vec++; if (fifo_count !== DEPTH) begin n_err++; $display("FAIL fill_count: got %0d want %0d", fifo_count, DEPTH); end
        push(data_in, acc);
        data_in_valid = 1'b0;
        n_vec++; if (acc != start_q[0] + FRAME + 1) begin
            n_err++; $display("FAIL fill_10th_accept: cycle %0d want %0d", acc, start_q[0] + FRAME + 1);
        end
        wait_drain(1500);
    endtask

    task automatic test_push_pop();
        int acc;
        int s;
        start_q.delete();
        for (int i = 0; i < 4; i++) push(8'($urandom), acc);
        data_in_valid = 1'b0;
        s = start_q[0];
        for (int i = 0; i < 500 && cyc < s + FRAME - 1; i++) step();
        n_vec++; if (fifo_count !== 3) begin n_err++; $display("FAIL pp_before: count %0d want 3", fifo_count); end
        data_in = 8'($urandom);
        data_in_valid = 1'b1;
        step();
        exp_q.push_back(data_in);
        data_in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (fifo_count !== 3) begin n_err++; $display("FAIL pp_after: count %0d want 3", fifo_count); end
        wait_drain(800);
    endtask

    task automatic test_reset_mid();
        int acc;
        int s;
        start_q.delete();
        for (int i = 0; i < 6; i++) push(8'($urandom), acc);
        data_in_valid = 1'b0;
        n_vec++; if (fifo_count !== 5) begin n_err++; $display("FAIL rm_queued: count %0d want 5", fifo_count); end
        s = start_q[0];
        for (int i = 0; i < 500 && cyc < s + 5 * SET + 4; i++) step();
        rst = 1'b1;
        data_in = 8'h77;
        data_in_valid = 1'b1;
        step();
        @(negedge clk);
        n_vec++; if (serial_out !== 1'b1) begin n_err++; $display("FAIL rm_serial: got %b want 1", serial_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_vec++; if (fifo_count !== 0) begin n_err++; $display("FAIL rm_count: got %0d want 0", fifo_count); end
        n_vec++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b want 1", data_in_ready); end
        rst = 1'b0;
        data_in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || fifo_count !== 0) begin
            n_err++; $display("FAIL rm_push_dropped: busy=%b count=%0d want 0/0", busy, fifo_count);
        end
        step();
        push(8'h3C, acc);
        data_in_valid = 1'b0;
        wait_drain(300);
    endtask

    task automatic test_random();
        int acc;
        for (int i = 0; i < 16; i++) begin
            push(8'($urandom), acc);
            data_in_valid = 1'b0;
            repeat ($urandom_range(0, 150)) step();
        end
        wait_drain(2000);
    endtask

    task automatic test_loopback();
        int acc;
        int f0 = n_frames;
        for (int b = 0; b < 256; b++) push(8'(b), acc);
        data_in_valid = 1'b0;
        wait_drain(2000);
        n_vec++; if (n_frames - f0 != 256) begin
            n_err++; $display("FAIL loopback_frames: got %0d want 256", n_frames - f0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_push_pop();
        test_reset_mid();
        test_random();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
